// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan path: digit count, the
// active-high segment pattern table and a decoder that maps a pattern
// back to a hex nibble (or to a blank digit).
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-high segment view, bit0=a .. bit6=g
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry i holds the pattern for hex digit i
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic       ok;
    logic       blank;
    logic [3:0] nibble;
  } seg_decode_t;

  // ok=0 means the pattern is neither a hex digit nor blank
  function automatic seg_decode_t seg_decode(input logic [6:0] s);
    seg_decode_t r;
    r = '0;
    if (s == SEG_BLANK) begin
      r.ok    = 1'b1;
      r.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (s == SEG_HEX_TABLE[i]) begin
          r.ok     = 1'b1;
          r.nibble = 4'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_sample_filter.sv
// Sample qualifier for the scanned display bus: a sample is usable only
// when exactly one anode is active, and a digit is accepted once after the
// same {segments, anodes} sample has been seen for STABLE_CYCLES cycles.
module seg_sample_filter
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [7:0] na,
  output logic       accept,
  output logic [2:0] digit_idx,
  output logic [6:0] digit_seg
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [7:0]       sel;
  logic             sample_ok;
  logic             same_sample;
  logic [14:0]      prev_sample;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_next;

  assign sel         = ~na;
  assign sample_ok   = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
  // A nonzero count implies prev_sample held a valid sample
  assign same_sample = (stable_cnt != '0) && ({seg, na} == prev_sample);
  assign digit_seg   = seg;

  // Next run length of the current sample, saturating so a held digit is not re-accepted
  always_comb begin
    cnt_next = '0;
    if (sample_ok) begin
      if (!same_sample) begin
        cnt_next = CNT_W'(1);
      end else if (stable_cnt == CNT_MAX) begin
        cnt_next = CNT_MAX;
      end else begin
        cnt_next = stable_cnt + CNT_W'(1);
      end
    end
  end

  assign accept = sample_ok && (cnt_next == CNT_MAX) &&
                  !(same_sample && (stable_cnt == CNT_MAX));

  // Position of the single active (low) anode
  always_comb begin
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) begin
        digit_idx = 3'(i);
      end
    end
  end

  // Remember the last sample and how long it has been stable
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt  <= '0;
      prev_sample <= '0;
    end else begin
      stable_cnt  <= cnt_next;
      prev_sample <= {seg, na};
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the multiplexed 7-segment bus: filters the scanned
// samples, decodes each digit, reassembles the 8-digit word and offers it
// on a valid/ready output with overrun, bad-pattern and timeout reporting.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int EMIT_ON_CHANGE = 0
) (
  input  logic        FPGA_GlobalClock,
  input  logic        RST,
  input  logic [7:0]  SEG,
  input  logic [7:0]  NA,
  output logic [31:0] value,
  output logic [7:0]  blank_mask,
  output logic        value_valid,
  input  logic        value_ready,
  output logic        bad_pattern,
  output logic        overrun,
  output logic        frame_timeout
);

  localparam int               TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic              accept;
  logic [2:0]        digit_idx;
  logic [6:0]        digit_seg;
  seg_decode_t       dec;
  logic              digit_good;
  logic              digit_bad;
  logic [7:0]        digit_bit;
  logic [7:0]        seen;
  logic [31:0]       shadow_value;
  logic [7:0]        shadow_blank;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              frame_done;
  logic [31:0]       last_value;
  logic [7:0]        last_blank;
  logic              last_ok;
  logic              same_as_last;
  logic              emit_frame;
  logic              unused_dp;

  // The decimal point carries no digit information
  assign unused_dp = SEG[7];

  seg_sample_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk       (FPGA_GlobalClock),
    .rst       (RST),
    .seg       (SEG[6:0]),
    .na        (NA),
    .accept    (accept),
    .digit_idx (digit_idx),
    .digit_seg (digit_seg)
  );

  // Segments are active-low on the bus, the table is active-high
  assign dec        = seg_decode(~digit_seg);
  assign digit_good = accept && dec.ok;
  assign digit_bad  = accept && !dec.ok;
  assign digit_bit  = 8'd1 << digit_idx;
  assign frame_done = (seen == 8'hFF);

  // last_ok keeps an all-zero first frame from matching the cleared history
  assign same_as_last = last_ok && (last_value == shadow_value) && (last_blank == shadow_blank);
  assign emit_frame   = frame_done && !((EMIT_ON_CHANGE != 0) && same_as_last);

  // Track which digits of the current frame have arrived and age out stale partial frames
  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      seen          <= '0;
      tmo_cnt       <= '0;
      frame_timeout <= 1'b0;
    end else begin
      frame_timeout <= 1'b0;
      if (frame_done) begin
        seen    <= digit_good ? digit_bit : 8'h00;
        tmo_cnt <= '0;
      end else if (digit_good) begin
        seen    <= seen | digit_bit;
        tmo_cnt <= '0;
      end else if (seen != 8'h00) begin
        if (tmo_cnt == TMO_LAST) begin
          seen          <= '0;
          tmo_cnt       <= '0;
          frame_timeout <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

  // Store accepted digits in the shadow frame and latch undecodable patterns
  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      shadow_value <= '0;
      shadow_blank <= '0;
      bad_pattern  <= 1'b0;
    end else begin
      if (digit_good) begin
        shadow_value[{digit_idx, 2'b00} +: 4] <= dec.nibble;
        shadow_blank[digit_idx]               <= dec.blank;
      end
      if (digit_bad) begin
        bad_pattern <= 1'b1;
      end
    end
  end

  // Hand completed frames to the consumer, flagging frames that find the output still held
  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      value       <= '0;
      blank_mask  <= '0;
      value_valid <= 1'b0;
      overrun     <= 1'b0;
      last_value  <= '0;
      last_blank  <= '0;
      last_ok     <= 1'b0;
    end else if (emit_frame && (!value_valid || value_ready)) begin
      value       <= shadow_value;
      blank_mask  <= shadow_blank;
      value_valid <= 1'b1;
      last_value  <= shadow_value;
      last_blank  <= shadow_blank;
      last_ok     <= 1'b1;
    end else begin
      if (emit_frame) begin
        overrun <= 1'b1;
      end
      if (value_valid && value_ready) begin
        value_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive end of the multiplexed 7-segment bus (SEG/NA) driven by the MIPS_CPU display path.
- Samples the scanned segment/anode signals, filters transients, and decodes each digit pattern back to a hex nibble.
- Reassembles the 8-digit display as a 32-bit word and presents it on a valid/ready output for on-board readback and self-check logic.

Parameters:
- STABLE_CYCLES, 4, consecutive identical valid samples required to accept a digit (>=1).
- TIMEOUT_CYCLES, 1000000, cycles without an accepted digit before the partial frame is discarded.
- EMIT_ON_CHANGE, 0, when 1 suppress frames equal (value and blank_mask) to the last emitted frame.

Ports:
- FPGA_GlobalClock  in  1  sole clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SEG  in  8  segments, active-low; bit0=a .. bit6=g, bit7=dp (dp ignored).
- NA  in  8  digit anodes, active-low; NA[k]=0 selects digit k = value[4k+3:4k].
- value  out  32  reconstructed display word.
- blank_mask  out  8  bit k=1: digit k was blank (all segments off) in the emitted frame.
- value_valid  out  1  frame available; held until value_ready.
- value_ready  in  1  consumer accept.
- bad_pattern  out  1  sticky: a stable sample held a non-hex, non-blank segment pattern.
- overrun  out  1  sticky: a completed frame was dropped because the output was still held.
- frame_timeout  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (RST=1 at edge): value=0, blank_mask=0, value_valid=0, bad_pattern=0, overrun=0, frame_timeout=0; seen mask, stability counter, timeout counter and last-emitted register cleared. Reset mid-frame discards all partial data.
- Valid sample: NA has exactly one zero bit. Zero or multiple zeros are invalid, restart the stability counter and are never accepted.
- Stability filter: counts consecutive cycles with identical {SEG[6:0],NA} forming a valid sample. On the cycle the count reaches STABLE_CYCLES, the digit is accepted once. No re-accept occurs until the input changes.
- Decode, active-high view s=~SEG[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - s=00 decodes as blank: nibble 0 and blank bit set.
  - Any other pattern sets bad_pattern. The digit is not stored and not marked seen.
- Acceptance writes nibble k and blank bit k into the shadow registers, sets seen[k], and clears the timeout counter. Re-accepting an already-seen digit overwrites it.
- Frame done: seen becomes 8'hFF. The shadow is copied to the output stage and seen is cleared in the same cycle, so capture is continuous.
- Output stage, evaluated on the edge after frame done:
  - If EMIT_ON_CHANGE=1 and the frame equals the last emitted frame: drop silently (no overrun).
  - Else if value_valid=0 or value_ready=1: load value and blank_mask, set value_valid=1, update last-emitted.
  - Else: set overrun=1; the held output is unchanged.
  - Latency: value_valid is high after edge E+1, where E is the edge accepting the 8th digit.
- Handshake:
  - value_valid & value_ready with no new load: value_valid drops next edge; value and blank_mask hold.
  - Simultaneous handshake and new load: the new frame is loaded and value_valid stays 1.
  - value/blank_mask are stable while value_valid=1.
- Timeout: counter increments each cycle while seen!=0. On reaching TIMEOUT_CYCLES-1: seen cleared, frame_timeout pulses one cycle, counter restarts. No effect while seen=0.
- Sticky flags clear only on RST.

Decomposition:
- Shared package seg_pkg:
  - localparam segment pattern table (16 hex codes plus blank).
  - localparam NUM_DIGITS=8.
  - function seg_decode(7-bit s) returning {ok, blank, nibble}; reusable by the display driver's checker.
- One sub-module seg_sample_filter: one-hot check plus STABLE_CYCLES stability counter, emitting a one-cycle accept with digit index and SEG.
- Decode, frame assembly, output handshake and timeout stay in seg_scan_capture.

Test Plan:
- Display 0x12345678: scan k=0..7 with SEG=~pattern, each held 6 cycles, value_ready=1 -> value=32'h12345678, blank_mask=0, value_valid high 1 cycle after 8th accept, flags 0.
- Glitch: digit held only STABLE_CYCLES-1 cycles, then NA=8'h00 and NA=8'hFF inserted -> no accept, seen unchanged, no value_valid.
- Bad pattern: digit 3 with SEG=8'hFE (segment a only) -> bad_pattern=1 sticky, frame not completed; a later good frame still emits.
- Backpressure: value_ready=0, two full frames 0xAAAAAAAA then 0x55555555 -> value holds 32'hAAAAAAAA, overrun=1; raise ready -> value_valid drops next cycle.
- Timeout with TIMEOUT_CYCLES=16: accept digits 0..3, then idle -> frame_timeout pulses once at 16 cycles after last accept; next full frame 0x0000FFFF emits correctly.
- EMIT_ON_CHANGE=1: same frame 0xDEADBEEF scanned twice, then 0xDEADBEEE -> exactly two value_valid events; blank digits (SEG=8'hFF) give blank_mask bits set and nibble 0.
